// File: rtl/me_sad_search.sv
// me_sad_search -- full-search block-matching motion estimator.
//
// Scans every candidate offset (i,j) in [-re,+re]^2, with re = min(r, R_MAX),
// in raster order (i outer, j inner). It accumulates the sum of absolute
// differences between a BLKxBLK current block and the displaced block in the
// search window, and reports the first candidate with the smallest SAD.
//
// Ports:
//   clk      sole clock, rising edge
//   reset    asynchronous active-high reset
//   go       start pulse, sampled only while idle
//   r        requested search range (clamped to R_MAX)
//   addrCur  current-block row address
//   rdatCur  current-block row (1-cycle synchronous read), pixel k at [k*PIX_W +: PIX_W]
//   addrRef  search-window row address
//   rdatRef  search-window row (1-cycle synchronous read), same packing
//   busy     high while a search is in progress
//   done     one-cycle completion pulse
//   m_i/m_j  best vertical/horizontal offset, two's complement
//   min_sad  SAD of the best candidate
//
// Optional feature: define ME_EARLY_TERM_EN to abandon a candidate once its
// partial SAD reaches the current best. Results are unchanged; only latency
// shrinks. The default build (macro undefined) scans every row of every
// candidate.
module me_sad_search #(
  parameter int PIX_W = 8,
  parameter int BLK   = 8,
  parameter int R_MAX = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               go,
  input  logic [3:0]                         r,
  output logic [$clog2(BLK)-1:0]             addrCur,
  input  logic [BLK*PIX_W-1:0]               rdatCur,
  output logic [$clog2(BLK+2*R_MAX)-1:0]     addrRef,
  input  logic [(BLK+2*R_MAX)*PIX_W-1:0]     rdatRef,
  output logic                               busy,
  output logic                               done,
  output logic [7:0]                         m_i,
  output logic [7:0]                         m_j,
  output logic [PIX_W+2*$clog2(BLK)-1:0]     min_sad
);
  localparam int AW_C  = $clog2(BLK);
  localparam int AW_R  = $clog2(BLK+2*R_MAX);
  localparam int WIN   = BLK+2*R_MAX;
  localparam int SAD_W = PIX_W+2*AW_C;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Row SAD against the window row shifted left by 'off' pixels.
  function automatic logic [SAD_W-1:0] row_sad(input logic [BLK*PIX_W-1:0] cur,
                                               input logic [WIN*PIX_W-1:0] win,
                                               input int                   off);
    logic [WIN*PIX_W-1:0] sh;
    logic [SAD_W-1:0]     s;
    sh = win >> (off*PIX_W);
    s  = '0;
    for (int k = 0; k < BLK; k++)
      s = s + SAD_W'(abs_diff(cur[k*PIX_W +: PIX_W], sh[k*PIX_W +: PIX_W]));
    return s;
  endfunction

  function automatic logic [AW_R-1:0] ref_addr(input logic [AW_C-1:0]  y,
                                               input logic signed [7:0] i);
    logic signed [15:0] s;
    s = signed'(16'(y)) + 16'(i) + 16'(R_MAX);
    return s[AW_R-1:0];
  endfunction

  logic [1:0]             state;
  logic                   drain_cnt;
  logic [3:0]             re_in;
  logic signed [7:0]      re_s, re_q;

  logic [AW_C-1:0]        y_p0, nxt_y;
  logic signed [7:0]      i_p0, j_p0, nxt_i, nxt_j;
  logic [AW_R-1:0]        addr_ref_q;
  logic                   search_end;

  logic                   vld_p1, first_p1, last_p1;
  logic signed [7:0]      i_p1, j_p1;
  logic [SAD_W-1:0]       rsad;

  logic                   vld_p2, last_p2;
  logic signed [7:0]      i_p2, j_p2;
  logic [SAD_W-1:0]       acc_p2;

  logic                   have_best, cmp_win;
  logic [SAD_W-1:0]       best_sad;
  logic signed [7:0]      best_i, best_j;

  logic                   abort, same_p0, same_p1, skip;

  assign re_in   = (r > 4'(R_MAX)) ? 4'(R_MAX) : r;
  assign re_s    = signed'({4'b0000, re_in});
  assign addrCur = y_p0;
  assign addrRef = addr_ref_q;
  assign busy    = (state != S_IDLE);

  // A partial sum that already reaches the best can never win (ties keep
  // the earlier candidate), so its remaining rows are dropped.
`ifdef ME_EARLY_TERM_EN
  assign abort = vld_p2 && !last_p2 && have_best && (acc_p2 >= best_sad);
`else
  assign abort = 1'b0;
`endif
  assign same_p0 = (i_p0 == i_p2) && (j_p0 == j_p2);
  assign same_p1 = (i_p1 == i_p2) && (j_p1 == j_p2);
  assign skip    = (state == S_SEARCH) && abort && same_p0;

  assign cmp_win = vld_p2 && last_p2 && (!have_best || (acc_p2 < best_sad));

  // Stage p0: address generation for the next row / candidate.
  always_comb begin
    nxt_y      = y_p0;
    nxt_i      = i_p0;
    nxt_j      = j_p0;
    search_end = 1'b0;
    if (skip || (y_p0 == AW_C'(BLK-1))) begin
      nxt_y = '0;
      if ((i_p0 == re_q) && (j_p0 == re_q)) begin
        search_end = 1'b1;
      end else if (j_p0 == re_q) begin
        nxt_j = -re_q;
        nxt_i = i_p0 + 8'sd1;
      end else begin
        nxt_j = j_p0 + 8'sd1;
      end
    end else begin
      nxt_y = y_p0 + AW_C'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      drain_cnt  <= 1'b0;
      y_p0       <= '0;
      addr_ref_q <= '0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      have_best  <= 1'b0;
      done       <= 1'b0;
      m_i        <= '0;
      m_j        <= '0;
      min_sad    <= '0;
    end else begin
      done   <= 1'b0;
      vld_p1 <= (state == S_SEARCH) && !skip;
      vld_p2 <= vld_p1 && !(abort && same_p1);
      if ((state == S_IDLE) && go)
        have_best <= 1'b0;
      else if (vld_p2 && last_p2)
        have_best <= 1'b1;
      case (state)
        S_IDLE: begin
          if (go) begin
            state      <= S_SEARCH;
            y_p0       <= '0;
            addr_ref_q <= ref_addr('0, -re_s);
          end
        end
        S_SEARCH: begin
          drain_cnt  <= 1'b0;
          y_p0       <= nxt_y;
          addr_ref_q <= ref_addr(nxt_y, nxt_i);
          if (search_end)
            state <= S_DRAIN;
        end
        // Two cycles let the last row pass the read and accumulate stages.
        S_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt)
            state <= S_DONE;
        end
        default: begin
          state   <= S_IDLE;
          done    <= 1'b1;
          m_i     <= best_i;
          m_j     <= best_j;
          min_sad <= best_sad;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && go) begin
      re_q <= re_s;
      i_p0 <= -re_s;
      j_p0 <= -re_s;
    end else if (state == S_SEARCH) begin
      i_p0 <= nxt_i;
      j_p0 <= nxt_j;
    end
    // Stage p1: row data returns from memory.
    first_p1 <= (y_p0 == '0);
    last_p1  <= (y_p0 == AW_C'(BLK-1));
    i_p1     <= i_p0;
    j_p1     <= j_p0;
    // Stage p2: row SAD accumulated into the candidate total.
    last_p2  <= last_p1;
    i_p2     <= i_p1;
    j_p2     <= j_p1;
    acc_p2   <= first_p1 ? rsad : (acc_p2 + rsad);
    // Compare: completed candidate replaces best only when strictly smaller.
    if (cmp_win) begin
      best_sad <= acc_p2;
      best_i   <= i_p2;
      best_j   <= j_p2;
    end
  end

  assign rsad = row_sad(rdatCur, rdatRef, int'(j_p1) + R_MAX);

endmodule

// File: tb/tb_me_sad_search.sv
module tb_me_sad_search;
  localparam int PIX_W = 8;
  localparam int BLK   = 8;
  localparam int R_MAX = 4;
  localparam int WIN   = BLK + 2*R_MAX;
  localparam int SAD_W = PIX_W + 2*$clog2(BLK);

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   go;
  logic [3:0]             r;
  logic [2:0]             addrCur;
  logic [BLK*PIX_W-1:0]   rdatCur;
  logic [3:0]             addrRef;
  logic [WIN*PIX_W-1:0]   rdatRef;
  logic                   busy;
  logic                   done;
  logic [7:0]             m_i;
  logic [7:0]             m_j;
  logic [SAD_W-1:0]       min_sad;

  me_sad_search #(.PIX_W(PIX_W), .BLK(BLK), .R_MAX(R_MAX)) dut (
    .clk(clk), .reset(reset), .go(go), .r(r),
    .addrCur(addrCur), .rdatCur(rdatCur),
    .addrRef(addrRef), .rdatRef(rdatRef),
    .busy(busy), .done(done), .m_i(m_i), .m_j(m_j), .min_sad(min_sad)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: data for an address appears one cycle later.
  logic [BLK*PIX_W-1:0] cur_mem [BLK];
  logic [WIN*PIX_W-1:0] ref_mem [WIN];
  always @(posedge clk) begin
    rdatCur <= cur_mem[addrCur];
    rdatRef <= ref_mem[addrRef];
  end

  // kind 0: window pixel (row,col) = row*16+col (all unique), current block
  //         copied from the window at offset (mi,mj)
  // kind 1: every pixel 0x40
  // kind 2: current 0xFF, window 0x00
  typedef struct {
    int kind;
    int mi;
    int mj;
    int r;
    int exp_i;
    int exp_j;
    int exp_sad;
    int exp_lat;
  } vec_t;

  vec_t tbl [7];
  vec_t sb [$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int kind, input int mi, input int mj);
    logic [WIN*PIX_W-1:0] rw;
    logic [BLK*PIX_W-1:0] cw;
    for (int row = 0; row < WIN; row++) begin
      for (int col = 0; col < WIN; col++)
        rw[col*PIX_W +: PIX_W] = (kind == 0) ? 8'(row*16 + col) :
                                 (kind == 1) ? 8'h40 : 8'h00;
      ref_mem[row] = rw;
    end
    for (int y = 0; y < BLK; y++) begin
      for (int k = 0; k < BLK; k++)
        cw[k*PIX_W +: PIX_W] = (kind == 0) ? 8'((y+mi+R_MAX)*16 + k+mj+R_MAX) :
                               (kind == 1) ? 8'h40 : 8'hFF;
      cur_mem[y] = cw;
    end
  endtask

  task automatic start(input vec_t v);
    fill(v.kind, v.mi, v.mj);
    @(negedge clk);
    r  = 4'(v.r);
    go = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    #1;
    go = 1'b0;
    chk("busy_after_go", 32'(busy), 32'd1);
  endtask

  // Waits for done after start(); optionally pulses go (r=4) mid-run.
  task automatic finish_run(input string tag, input bit stray);
    vec_t e;
    int   n;
    bit   seen;
    n    = 0;
    seen = 1'b0;
    while (n < 2000 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      go = 1'b0;
      if (done) seen = 1'b1;
      else if (stray && n == 3) begin
        go = 1'b1;
        r  = 4'd4;
      end
    end
    go = 1'b0;
    e  = sb.pop_front();
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: no done within %0d cycles, expected at %0d", tag, n, e.exp_lat);
    end else begin
      chk({tag, "_m_i"}, 32'(m_i), 32'(e.exp_i));
      chk({tag, "_m_j"}, 32'(m_j), 32'(e.exp_j));
      chk({tag, "_min_sad"}, 32'(min_sad), 32'(e.exp_sad));
`ifdef ME_EARLY_TERM_EN
      n_chk++;
      if (n > e.exp_lat) begin
        n_fail++;
        $display("FAIL %s_latency: got %0d expected at most %0d", tag, n, e.exp_lat);
      end
`else
      chk({tag, "_latency"}, 32'(n), 32'(e.exp_lat));
`endif
      @(posedge clk);
      #1;
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_idle_after"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    tbl[0] = '{0,  2, -1, 4, 8'h02, 8'hFF,     0, 651};
    tbl[1] = '{1,  0,  0, 3, 8'hFD, 8'hFD,     0, 395};
    tbl[2] = '{0,  2, -1, 9, 8'h02, 8'hFF,     0, 651};
    tbl[3] = '{2,  0,  0, 0, 8'h00, 8'h00, 16320,  11};
    tbl[4] = '{0, -4, -4, 4, 8'hFC, 8'hFC,     0, 651};
    tbl[5] = '{0,  4,  4, 4, 8'h04, 8'h04,     0, 651};
    tbl[6] = '{0,  2, -1, 1, 8'h01, 8'h01,   896,  75};

    reset = 1'b1;
    go    = 1'b0;
    r     = 4'd0;
    fill(1, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_m_i", 32'(m_i), 32'd0);
    chk("rst_m_j", 32'(m_j), 32'd0);
    chk("rst_min_sad", 32'(min_sad), 32'd0);
    chk("rst_addrCur", 32'(addrCur), 32'd0);
    chk("rst_addrRef", 32'(addrRef), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    for (int t = 0; t < 7; t++) begin
      start(tbl[t]);
      finish_run($sformatf("vec%0d", t), 1'b0);
    end

    // Reset 100 cycles into an r=4 search: abort, no done, outputs cleared.
    start(tbl[0]);
    repeat (99) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    sb.delete();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_m_i", 32'(m_i), 32'd0);
    chk("abort_m_j", 32'(m_j), 32'd0);
    chk("abort_min_sad", 32'(min_sad), 32'd0);
    chk("abort_addrCur", 32'(addrCur), 32'd0);
    chk("abort_addrRef", 32'(addrRef), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    dcount = 0;
    for (int c = 0; c < 700; c++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    chk("abort_no_done", 32'(dcount), 32'd0);
    start(tbl[0]);
    finish_run("after_abort", 1'b0);

    // go while busy (with a different r) must be ignored.
    start(tbl[3]);
    finish_run("stray_go", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
